// File: rtl/memory_access.sv
// Memory stage: word load/store against a local data memory, beq/bne
// resolution, MEM/WB register, sticky fault flag and saturating debug counters.
module memory_access #(
   parameter int MEM_WORDS = 64,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [44:0]          EXMEM,
   input  logic [31:0]          ALUresult,
   input  logic [31:0]          WRITE_DATA,
   input  logic                 Zero,
   input  logic [7:0]           PCBranch_EXMEM,
   output logic                 PCSrc,
   output logic [7:0]           PCBranch_out,
   output logic                 FLUSH,
   output logic                 MEMWB_RegWrite,
   output logic                 MEMWB_MemtoReg,
   output logic [4:0]           MEMWB_RD,
   output logic [31:0]          READ_DATA,
   output logic [31:0]          ALUresult_MEMWB,
   output logic                 MEM_FAULT,
   output logic [CNT_WIDTH-1:0] LOAD_COUNT,
   output logic [CNT_WIDTH-1:0] STORE_COUNT,
   output logic [CNT_WIDTH-1:0] TAKEN_COUNT
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

   logic          reg_write, mem_to_reg, mem_read, mem_write, branch;
   logic [2:0]    funct3;
   logic [4:0]    rd;
   logic [AW-1:0] idx;
   logic          legal, is_load, is_store, ld_ok, st_ok, fault_ev;
   logic [31:0]   mem [MEM_WORDS];

   assign reg_write  = EXMEM[36];
   assign mem_to_reg = EXMEM[35];
   assign mem_read   = EXMEM[34];
   assign mem_write  = EXMEM[33];
   assign branch     = EXMEM[32];
   assign funct3     = EXMEM[14:12];
   assign rd         = EXMEM[11:7];
   assign idx        = ALUresult[AW+1:2];

   // Fields of the pipeline register this stage does not consume.
   logic unused_bits;
   assign unused_bits = ^{EXMEM[44:37], EXMEM[31:15], EXMEM[6:0]};

   // Word aligned and inside the memory; both read/write set counts as a store.
   assign legal    = (ALUresult[1:0] == 2'b00) && ((ALUresult >> (AW + 2)) == 32'd0);
   assign is_store = mem_write;
   assign is_load  = mem_read & ~mem_write;
   assign ld_ok    = is_load & legal;
   assign st_ok    = is_store & legal;
   assign fault_ev = (is_load | is_store) & ~legal;

   // Branch resolution: beq takes on Zero, bne on ~Zero, anything else never.
   always_comb begin
      PCSrc = 1'b0;
      if (branch) begin
         case (funct3)
            3'b000:  PCSrc = Zero;
            3'b001:  PCSrc = ~Zero;
            default: PCSrc = 1'b0;
         endcase
      end
   end

   assign FLUSH        = PCSrc;
   assign PCBranch_out = PCBranch_EXMEM;

   // Data memory write port; contents are not reset, but a store seen while
   // reset is held is dropped.
   always_ff @(posedge clk) begin
      if (rst_n && st_ok) mem[idx] <= WRITE_DATA;
   end

   // MEM/WB register and sticky fault flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         MEMWB_RegWrite  <= 1'b0;
         MEMWB_MemtoReg  <= 1'b0;
         MEMWB_RD        <= '0;
         READ_DATA       <= '0;
         ALUresult_MEMWB <= '0;
         MEM_FAULT       <= 1'b0;
      end else begin
         MEMWB_RegWrite  <= reg_write & ~(is_load & ~legal);
         MEMWB_MemtoReg  <= mem_to_reg;
         MEMWB_RD        <= rd;
         READ_DATA       <= ld_ok ? mem[idx] : 32'd0;
         ALUresult_MEMWB <= ALUresult;
         if (fault_ev) MEM_FAULT <= 1'b1;
      end
   end

   // Saturating event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         LOAD_COUNT  <= '0;
         STORE_COUNT <= '0;
         TAKEN_COUNT <= '0;
      end else begin
         if (ld_ok && (LOAD_COUNT != '1))  LOAD_COUNT  <= LOAD_COUNT + CNT_ONE;
         if (st_ok && (STORE_COUNT != '1)) STORE_COUNT <= STORE_COUNT + CNT_ONE;
         if (PCSrc && (TAKEN_COUNT != '1)) TAKEN_COUNT <= TAKEN_COUNT + CNT_ONE;
      end
   end
endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed vectors, a spec-level model checked every
// cycle, and literal expectations at the interesting points.
module tb_memory_access;
   localparam int MW   = 64;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [44:0]   EXMEM;
   logic [31:0]   ALUresult, WRITE_DATA;
   logic          Zero;
   logic [7:0]    PCBranch_EXMEM;
   logic          PCSrc, FLUSH, MEMWB_RegWrite, MEMWB_MemtoReg, MEM_FAULT;
   logic [7:0]    PCBranch_out;
   logic [4:0]    MEMWB_RD;
   logic [31:0]   READ_DATA, ALUresult_MEMWB;
   logic [CW-1:0] LOAD_COUNT, STORE_COUNT, TAKEN_COUNT;

   always #5 clk = ~clk;

   memory_access #(.MEM_WORDS(MW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .EXMEM(EXMEM), .ALUresult(ALUresult),
      .WRITE_DATA(WRITE_DATA), .Zero(Zero), .PCBranch_EXMEM(PCBranch_EXMEM),
      .PCSrc(PCSrc), .PCBranch_out(PCBranch_out), .FLUSH(FLUSH),
      .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_MemtoReg(MEMWB_MemtoReg),
      .MEMWB_RD(MEMWB_RD), .READ_DATA(READ_DATA), .ALUresult_MEMWB(ALUresult_MEMWB),
      .MEM_FAULT(MEM_FAULT), .LOAD_COUNT(LOAD_COUNT), .STORE_COUNT(STORE_COUNT),
      .TAKEN_COUNT(TAKEN_COUNT)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   logic [31:0] mmem [int];
   bit          e_rw = 0, e_m2r = 0, e_fault = 0, e_known = 1;
   logic [4:0]  e_rd = 0;
   logic [31:0] e_rdata = 0, e_alu = 0;
   int          e_ld = 0, e_st = 0, e_tk = 0;

   function automatic bit exp_taken();
      if (!EXMEM[32]) return 1'b0;
      if (EXMEM[14:12] == 3'b000) return Zero;      // beq
      if (EXMEM[14:12] == 3'b001) return !Zero;     // bne
      return 1'b0;
   endfunction

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_rw = 0; e_m2r = 0; e_rd = 0; e_rdata = 0; e_alu = 0;
         e_fault = 0; e_known = 1; e_ld = 0; e_st = 0; e_tk = 0;
      end else begin
         automatic bit ok = (ALUresult % 4 == 0) && (ALUresult < MW * 4);
         automatic int i  = int'(ALUresult / 4);
         e_rw = EXMEM[36]; e_m2r = EXMEM[35]; e_rd = EXMEM[11:7];
         e_alu = ALUresult; e_rdata = 0; e_known = 1;
         if (EXMEM[33]) begin
            if (ok) begin mmem[i] = WRITE_DATA; e_st = sat(e_st); end
            else e_fault = 1;
         end else if (EXMEM[34]) begin
            if (ok) begin
               if (mmem.exists(i)) e_rdata = mmem[i]; else e_known = 0;
               e_ld = sat(e_ld);
            end else begin
               e_rw = 0; e_fault = 1;
            end
         end
         if (exp_taken()) e_tk = sat(e_tk);
      end
   end

   // Compare process: registered outputs settle after the edge, inputs hold
   // until the next falling edge.
   always @(posedge clk) begin
      #2;
      chk("m_regwrite", 32'(MEMWB_RegWrite), 32'(e_rw));
      chk("m_memtoreg", 32'(MEMWB_MemtoReg), 32'(e_m2r));
      chk("m_rd",       32'(MEMWB_RD),       32'(e_rd));
      if (e_known) chk("m_read_data", READ_DATA, e_rdata);
      chk("m_alu",      ALUresult_MEMWB,     e_alu);
      chk("m_fault",    32'(MEM_FAULT),      32'(e_fault));
      chk("m_ld_cnt",   32'(LOAD_COUNT),     32'(e_ld));
      chk("m_st_cnt",   32'(STORE_COUNT),    32'(e_st));
      chk("m_tk_cnt",   32'(TAKEN_COUNT),    32'(e_tk));
      chk("m_pcsrc",    32'(PCSrc),          32'(exp_taken()));
      chk("m_flush",    32'(FLUSH),          32'(exp_taken()));
      chk("m_pcb",      32'(PCBranch_out),   32'(PCBranch_EXMEM));
   end

   // ---------------- stimulus ----------------
   task automatic set(input bit rw, m2r, mr, mw, br, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [31:0] alu, wd,
                      input bit z, input logic [7:0] pcb);
      EXMEM = {8'hA5, rw, m2r, mr, mw, br, 17'h1F0F0, f3, rd, 7'h23};
      ALUresult = alu; WRITE_DATA = wd; Zero = z; PCBranch_EXMEM = pcb;
   endtask

   task automatic sw(input logic [31:0] a, d);
      set(0, 0, 0, 1, 0, 3'b010, 5'd0, a, d, 0, 8'h00);
   endtask
   task automatic lw(input logic [31:0] a, input logic [4:0] rd);
      set(1, 1, 1, 0, 0, 3'b010, rd, a, 32'h0, 0, 8'h00);
   endtask
   task automatic br(input logic [2:0] f3, input bit z, input logic [7:0] pcb);
      set(0, 0, 0, 0, 1, f3, 5'd0, 32'h0000_0004, 32'h0, z, pcb);
   endtask
   task automatic idle();
      set(0, 0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 1, 8'h00);
   endtask
   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (3) tick();
      rst_n = 1'b1;

      // store then load, same address
      sw(32'h10, 32'hDEADBEEF); tick();
      lw(32'h10, 5'd5); tick();
      chk("sl_data", READ_DATA, 32'hDEADBEEF);
      chk("sl_rd", 32'(MEMWB_RD), 32'd5);
      chk("sl_ld_cnt", 32'(LOAD_COUNT), 32'd1);
      chk("sl_st_cnt", 32'(STORE_COUNT), 32'd1);
      sw(32'h14, 32'h12345678); tick();
      lw(32'h14, 5'd7); tick();
      chk("sl2_data", READ_DATA, 32'h12345678);

      // branches
      br(3'b000, 1, 8'h24); #1;
      chk("beq_pcsrc", 32'(PCSrc), 32'd1);
      chk("beq_flush", 32'(FLUSH), 32'd1);
      chk("beq_pcb", 32'(PCBranch_out), 32'h24);
      tick();
      chk("beq_taken", 32'(TAKEN_COUNT), 32'd1);
      br(3'b001, 1, 8'h30); #1;
      chk("bne_z1", 32'(PCSrc), 32'd0);
      tick();
      br(3'b001, 0, 8'h40); #1;
      chk("bne_z0", 32'(PCSrc), 32'd1);
      tick();
      br(3'b010, 1, 8'h44); #1;
      chk("br_f3_other", 32'(PCSrc), 32'd0);
      tick();
      chk("taken2", 32'(TAKEN_COUNT), 32'd2);

      // misaligned store
      sw(32'h12, 32'hBAD0BAD0); tick();
      chk("mis_fault", 32'(MEM_FAULT), 32'd1);
      chk("mis_st_cnt", 32'(STORE_COUNT), 32'd2);
      lw(32'h10, 5'd3); tick();
      chk("mis_mem", READ_DATA, 32'hDEADBEEF);
      idle();
      repeat (100) tick();
      chk("mis_sticky", 32'(MEM_FAULT), 32'd1);

      // asynchronous reset mid-cycle with outputs nonzero
      lw(32'h14, 5'd7); tick();
      #2 rst_n = 1'b0; #1;
      chk("rst_regwrite", 32'(MEMWB_RegWrite), 32'd0);
      chk("rst_memtoreg", 32'(MEMWB_MemtoReg), 32'd0);
      chk("rst_rd", 32'(MEMWB_RD), 32'd0);
      chk("rst_data", READ_DATA, 32'd0);
      chk("rst_alu", ALUresult_MEMWB, 32'd0);
      chk("rst_fault", 32'(MEM_FAULT), 32'd0);
      chk("rst_ld", 32'(LOAD_COUNT), 32'd0);
      chk("rst_st", 32'(STORE_COUNT), 32'd0);
      chk("rst_tk", 32'(TAKEN_COUNT), 32'd0);
      sw(32'h10, 32'h55555555); tick();     // edge seen with reset low
      idle(); rst_n = 1'b1;
      lw(32'h10, 5'd9); tick();
      chk("rst_drop_store", READ_DATA, 32'hDEADBEEF);
      chk("rst_drop_st_cnt", 32'(STORE_COUNT), 32'd0);

      // out-of-range load
      lw(32'h100, 5'd4); tick();
      chk("oor_data", READ_DATA, 32'd0);
      chk("oor_regwrite", 32'(MEMWB_RegWrite), 32'd0);
      chk("oor_fault", 32'(MEM_FAULT), 32'd1);
      chk("oor_ld_cnt", 32'(LOAD_COUNT), 32'd1);

      // read+write together: store only
      set(1, 0, 1, 1, 0, 3'b010, 5'd6, 32'h18, 32'h00000077, 0, 8'h00); tick();
      chk("rw_data", READ_DATA, 32'd0);
      chk("rw_st_cnt", 32'(STORE_COUNT), 32'd1);
      chk("rw_ld_cnt", 32'(LOAD_COUNT), 32'd1);
      lw(32'h18, 5'd6); tick();
      chk("rw_mem", READ_DATA, 32'h00000077);

      // back-to-back stores then loads
      for (int k = 0; k < 8; k++) begin
         sw(32'h20 + 32'(k * 4), 32'hA000_0000 + 32'(k * 32'h0101)); tick();
      end
      for (int k = 7; k >= 0; k--) begin
         lw(32'h20 + 32'(k * 4), 5'(k + 10)); tick();
      end
      chk("b2b_last", READ_DATA, 32'hA000_0000);

      // load counter saturation
      for (int k = 0; k < 20; k++) begin
         lw(32'h10, 5'd1); tick();
      end
      chk("sat_ld", 32'(LOAD_COUNT), 32'd15);
      lw(32'h14, 5'd2); tick();
      chk("sat_hold", 32'(LOAD_COUNT), 32'd15);

      idle(); tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
